// File: rtl/imem_loader_if.sv
// imem_loader_if: program byte stream plus instruction-memory write port of the loader
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_wEn;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  modport master (output in_valid, in_data, input in_ready, mem_wEn, mem_addr, mem_wdata);
  modport slave  (input in_valid, in_data, output in_ready, mem_wEn, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: streams program bytes into instruction memory while holding the core in reset; IMEM_LOAD_CHECKSUM_EN adds a trailer-byte check
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  imem_loader_if.slave      bus,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] cnt, addr;
  logic [ADDR_W:0]   len_r;
  logic [7:0]        wdata;
  logic              wen, xfer, last, len_ok, take, bad_sum;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0] sum;
  logic       chk_xfer;
  assign chk_xfer = state == CHECK && bus.in_valid;
  assign bad_sum  = chk_xfer && bus.in_data != sum;
  localparam state_t END_ST = CHECK;
`else
  assign bad_sum = 1'b0;
  localparam state_t END_ST = DONE;
`endif
  assign busy          = state == LOAD || state == CHECK;
  assign done          = state == DONE;
  assign core_rst      = state != DONE;
  assign bus.in_ready  = busy;
  assign bus.mem_wEn   = wen;
  assign bus.mem_addr  = 64'(addr);
  assign bus.mem_wdata = wdata;
  assign xfer   = state == LOAD && bus.in_valid;
  assign last   = {1'b0, cnt} == len_r - 1'b1;
  // legal lengths are 1..2^ADDR_W: nonzero, and with the top bit set only for exactly 2^ADDR_W
  assign len_ok = |len && !(len[ADDR_W] && |len[ADDR_W-1:0]);
  assign take   = start && (state == IDLE || state == DONE);
  always_comb begin
    nxt = state;
    if (take) nxt = len_ok ? LOAD : IDLE;
    else if (xfer && last) nxt = END_ST;
`ifdef IMEM_LOAD_CHECKSUM_EN
    else if (chk_xfer) nxt = bad_sum ? IDLE : DONE;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      len_r <= '0;
      addr  <= '0;
      wdata <= '0;
      wen   <= 1'b0;
      err   <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum   <= '0;
`endif
    end else begin
      state <= nxt;
      wen   <= xfer;
      if (xfer) begin
        addr  <= cnt;
        wdata <= bus.in_data;
        cnt   <= cnt + 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
        sum   <= sum + bus.in_data;
`endif
      end
      if (take) begin
        cnt <= '0;
        err <= !len_ok;
        if (len_ok) len_r <= len;
`ifdef IMEM_LOAD_CHECKSUM_EN
        sum <= '0;
`endif
      end
      if (bad_sum) err <= 1'b1;
    end
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning instruction memory byte-address width (capacity 2^ADDR_W bytes).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a program load.
REQ-005 SHALL have port len  input  ADDR_W+1  program length in bytes, sampled when start is accepted.
REQ-006 SHALL have port in_valid  input  1  source presents a program byte.
REQ-007 SHALL have port in_data  input  8  program byte.
REQ-008 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port mem_wEn  output  1  instruction memory write enable.
REQ-010 SHALL have port mem_addr  output  64  instruction memory byte address, same width as PC.
REQ-011 SHALL have port mem_wdata  output  8  byte written to instruction memory.
REQ-012 SHALL have port core_rst  output  1  holds the processor core in reset while high.
REQ-013 SHALL have ports busy, done, err  output  1 each  load in progress, program loaded, load failed.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, CHECK, DONE; CHECK is reachable only when IMEM_LOAD_CHECKSUM_EN is defined.
REQ-015 A byte transfer SHALL occur only in a cycle where in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL be 1 in LOAD and CHECK, and 0 in IDLE and DONE.
REQ-017 In IDLE or DONE, start=1 with 1<=len<=2^ADDR_W SHALL latch len, clear the byte counter and err, set core_rst=1, and enter LOAD the next cycle.
REQ-018 In IDLE or DONE, start=1 with len=0 or len>2^ADDR_W SHALL set err=1, core_rst=1, and enter or stay in IDLE.
REQ-019 start SHALL be ignored in LOAD and CHECK.
REQ-020 Each LOAD transfer SHALL produce, in the next cycle only, mem_wEn=1, mem_addr=zero-extended counter value, and mem_wdata=accepted byte; then the counter SHALL increment.
REQ-021 mem_wEn SHALL be 0 in every cycle not following a LOAD transfer.
REQ-022 The transfer with counter=len-1 SHALL end LOAD: next state CHECK when the macro is defined, otherwise DONE.
REQ-023 In DONE, done=1 and core_rst=0; the last mem_wEn pulse SHALL coincide with the first DONE cycle.
REQ-024 busy SHALL be 1 exactly in LOAD and CHECK.
REQ-025 err SHALL stay set until rst or the next accepted start.
REQ-026 Counter SHALL never exceed 2^ADDR_W-1; addresses never wrap within a load.

Reset
REQ-027 rst=1 SHALL take priority over all inputs, including mid-load, and force state IDLE, counter 0, in_ready=0, mem_wEn=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, core_rst=1.
REQ-028 A write pending at reset SHALL be dropped; bytes already written remain in memory.

Configuration
REQ-029 With IMEM_LOAD_CHECKSUM_EN defined, the loader SHALL keep an 8-bit modulo-256 sum of LOAD bytes, accept one trailer byte in CHECK without writing it, then go to DONE if trailer equals sum, else set err=1 and go to IDLE with core_rst=1.
REQ-030 Without IMEM_LOAD_CHECKSUM_EN, no sum SHALL be kept, no trailer SHALL be consumed, and LOAD SHALL go directly to DONE.

Verification
REQ-031 rst, then start with len=3 and bytes 0x30,0xF2,0x00 sent back-to-back -> writes at addresses 0,1,2; done=1 and core_rst=0 in the cycle of the third mem_wEn.
REQ-032 len=4, in_valid toggled every other cycle -> exactly 4 mem_wEn pulses at addresses 0..3 in order; no write without a preceding transfer.
REQ-033 start with len=0, then with len=2^ADDR_W+1 -> err=1, state IDLE, no writes, in_ready=0.
REQ-034 rst asserted after 2 of 5 bytes -> all outputs reach their reset values next cycle; a new start with len=1 loads address 0.
REQ-035 Macro defined, bytes 0x10,0x20 with trailer 0x30 -> done=1; trailer 0x31 -> err=1, core_rst=1, IDLE; no write for either trailer.
REQ-036 start pulsed during LOAD with a different len -> ignored; the original length is completed.
